// File: rtl/iob_soc_sut_arb_pkg.sv
// iob_soc_sut_arb_pkg: shared FSM encoding, field-slice macro and defaults for the IOb arbiter
`ifndef IOB_SOC_SUT_ARB_PKG_SV
`define IOB_SOC_SUT_ARB_PKG_SV
`define IOB_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]
package iob_soc_sut_arb_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_t;
  localparam int TIMEOUT_W_DEF = 8;
endpackage
`endif

// File: rtl/iob_soc_sut_rr_sel.sv
// iob_soc_sut_rr_sel: first requester at or after the pointer, modulo n
module iob_soc_sut_rr_sel #(
  parameter int N  = 2,
  parameter int GW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) idx = GW'((int'(ptr) + i) % N);
    end
  end
endmodule

// File: rtl/iob_soc_sut_iob_arbiter.sv
// iob_soc_sut_iob_arbiter: round-robin sharing of one IOb subordinate with read routing and watchdog
module iob_soc_sut_iob_arbiter
  import iob_soc_sut_arb_pkg::*;
#(
  parameter int N_MANAGERS = 2,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT_W  = TIMEOUT_W_DEF
) (
  input  logic                           clk_i,
  input  logic                           cke_i,
  input  logic                           arst_i,
  input  logic [N_MANAGERS-1:0]          m_avalid_i,
  input  logic [N_MANAGERS*ADDR_W-1:0]   m_addr_i,
  input  logic [N_MANAGERS*DATA_W-1:0]   m_wdata_i,
  input  logic [N_MANAGERS*DATA_W/8-1:0] m_wstrb_i,
  output logic [N_MANAGERS-1:0]          m_ready_o,
  output logic [N_MANAGERS-1:0]          m_rvalid_o,
  output logic [DATA_W-1:0]              m_rdata_o,
  output logic                           s_avalid_o,
  output logic [ADDR_W-1:0]              s_addr_o,
  output logic [DATA_W-1:0]              s_wdata_o,
  output logic [DATA_W/8-1:0]            s_wstrb_o,
  input  logic                           s_ready_i,
  input  logic                           s_rvalid_i,
  input  logic [DATA_W-1:0]              s_rdata_i,
  output logic [$clog2(N_MANAGERS)-1:0]  grant_o,
  output logic                           err_o
);
  localparam int GW = $clog2(N_MANAGERS);
  localparam int SW = DATA_W / 8;
  localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;
  arb_state_t state;
  logic [GW-1:0] ptr, nxt, sel;
  logic [TIMEOUT_W-1:0] wdog;
  logic any, busy, wait_rd, g_av, rd, xfer, tmo, rv;
  logic [N_MANAGERS-1:0] oh;
  iob_soc_sut_rr_sel #(.N(N_MANAGERS), .GW(GW)) u_sel (
    .req (m_avalid_i),
    .ptr (ptr),
    .idx (sel),
    .any (any)
  );
  always_comb begin
    busy       = state == BUSY;
    wait_rd    = state == WAIT_RD;
    g_av       = m_avalid_i[grant_o];
    s_addr_o   = `IOB_SLICE(m_addr_i, int'(grant_o), ADDR_W);
    s_wdata_o  = `IOB_SLICE(m_wdata_i, int'(grant_o), DATA_W);
    s_wstrb_o  = `IOB_SLICE(m_wstrb_i, int'(grant_o), SW);
    rd         = ~|s_wstrb_o;
    s_avalid_o = cke_i & busy & g_av;
    xfer       = s_avalid_o & s_ready_i;
    // timeout response carries zero data even if the subordinate drives garbage
    tmo        = wait_rd & ~s_rvalid_i & (wdog == WD_MAX);
    rv         = cke_i & ((xfer & rd & s_rvalid_i) | (wait_rd & (s_rvalid_i | tmo)));
    oh         = {{(N_MANAGERS-1){1'b0}}, 1'b1} << grant_o;
    m_ready_o  = (cke_i & busy & s_ready_i) ? oh : '0;
    m_rvalid_o = rv ? oh : '0;
    m_rdata_o  = tmo ? '0 : s_rdata_i;
    nxt        = (grant_o == GW'(N_MANAGERS - 1)) ? '0 : grant_o + 1'b1;
  end
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state   <= IDLE;
      grant_o <= '0;
      ptr     <= '0;
      wdog    <= '0;
      err_o   <= 1'b0;
    end else if (cke_i) begin
      case (state)
        IDLE: if (any) begin
          grant_o <= sel;
          state   <= BUSY;
        end
        BUSY: if (!g_av) begin
          ptr   <= nxt;
          state <= IDLE;
        end else if (s_ready_i) begin
          ptr   <= nxt;
          wdog  <= '0;
          state <= (rd && !s_rvalid_i) ? WAIT_RD : IDLE;
        end
        WAIT_RD: if (s_rvalid_i) state <= IDLE;
        else if (tmo) begin
          err_o <= 1'b1;
          state <= IDLE;
        end else wdog <= wdog + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iob_soc_sut_iob_arbiter.sv
// tb_iob_soc_sut_iob_arbiter: directed checks of grant, routing, watchdog and reset behaviour
module tb_iob_soc_sut_iob_arbiter;
  logic        clk = 1'b0, cke = 1'b1, arst = 1'b1;
  logic [1:0]  m_avalid = '0, m_ready, m_rvalid;
  logic [31:0] m_addr = '0;
  logic [63:0] m_wdata = '0;
  logic [7:0]  m_wstrb = '0;
  logic [31:0] m_rdata, s_wdata, s_rdata = '0;
  logic        s_avalid, s_ready = 1'b0, s_rvalid = 1'b0, grant, err;
  logic [15:0] s_addr;
  logic [3:0]  s_wstrb;
  int n_chk = 0, n_fail = 0, bad;
  always #5 clk = ~clk;
  iob_soc_sut_iob_arbiter #(.N_MANAGERS(2), .ADDR_W(16), .DATA_W(32), .TIMEOUT_W(4)) dut (
    .clk_i(clk), .cke_i(cke), .arst_i(arst),
    .m_avalid_i(m_avalid), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
    .m_ready_o(m_ready), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
    .s_avalid_o(s_avalid), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
    .s_ready_i(s_ready), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .grant_o(grant), .err_o(err)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #3;
    check("rst_grant", grant, 0);
    check("rst_err", err, 0);
    check("rst_savalid", s_avalid, 0);
    check("rst_ready", m_ready, 0);
    check("rst_rvalid", m_rvalid, 0);
    #9 arst = 1'b0;
    // single write from manager 0
    step;
    m_avalid = 2'b01; m_addr[15:0] = 16'h0004; m_wdata[31:0] = 32'hA5A5_0001; m_wstrb[3:0] = 4'hF;
    s_ready = 1'b1;
    #1;
    check("wr_idle_savalid", s_avalid, 0);
    check("wr_idle_ready", m_ready, 0);
    step;
    check("wr_savalid", s_avalid, 1);
    check("wr_addr", s_addr, 16'h0004);
    check("wr_wdata", s_wdata, 32'hA5A5_0001);
    check("wr_wstrb", s_wstrb, 4'hF);
    check("wr_ready", m_ready, 2'b01);
    check("wr_rvalid", m_rvalid, 0);
    check("wr_grant", grant, 0);
    step;
    m_avalid = 2'b00;
    #1;
    check("wr_done_ready", m_ready, 0);
    check("wr_done_savalid", s_avalid, 0);
    // fairness: pointer now at 1, both managers keep writing
    m_avalid = 2'b11; m_addr = {16'h0200, 16'h0100}; m_wstrb = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      step;
      check($sformatf("rr_grant%0d", i), grant, (i % 2 == 0) ? 1 : 0);
      check($sformatf("rr_ready%0d", i), m_ready, (i % 2 == 0) ? 2'b10 : 2'b01);
      check($sformatf("rr_addr%0d", i), s_addr, (i % 2 == 0) ? 16'h0200 : 16'h0100);
      step;
    end
    m_avalid = 2'b00;
    // delayed read by manager 1 while manager 0 waits with a write
    m_avalid = 2'b11; m_addr = {16'h0010, 16'h0300}; m_wstrb = 8'h0F;
    step;
    check("rd_grant", grant, 1);
    check("rd_addr", s_addr, 16'h0010);
    check("rd_wstrb", s_wstrb, 0);
    check("rd_ready", m_ready, 2'b10);
    check("rd_rvalid_acc", m_rvalid, 0);
    step;
    m_avalid = 2'b01;
    #1;
    check("rd_wait_savalid", s_avalid, 0);
    check("rd_wait_rvalid", m_rvalid, 0);
    step;
    check("rd_wait2_rvalid", m_rvalid, 0);
    check("rd_wait2_savalid", s_avalid, 0);
    step;
    s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
    #1;
    check("rd_rvalid", m_rvalid, 2'b10);
    check("rd_rdata", m_rdata, 32'h1234_5678);
    step;
    s_rvalid = 1'b0;
    #1;
    check("rd_after_savalid", s_avalid, 0);
    step;
    check("rd_next_grant", grant, 0);
    check("rd_next_addr", s_addr, 16'h0300);
    check("rd_next_ready", m_ready, 2'b01);
    step;
    m_avalid = 2'b00;
    // zero-latency read by manager 0; rvalid in IDLE must not leak
    m_avalid = 2'b01; m_addr[15:0] = 16'h0020; m_wstrb = 8'h00;
    s_rvalid = 1'b1; s_rdata = 32'hCAFE_F00D;
    #1;
    check("zl_idle_rvalid", m_rvalid, 0);
    step;
    check("zl_ready", m_ready, 2'b01);
    check("zl_rvalid", m_rvalid, 2'b01);
    check("zl_rdata", m_rdata, 32'hCAFE_F00D);
    step;
    m_avalid = 2'b00;
    #1;
    check("zl_after_rvalid", m_rvalid, 0);
    check("zl_after_savalid", s_avalid, 0);
    s_rvalid = 1'b0;
    // watchdog timeout on a read by manager 1
    m_avalid = 2'b10; m_addr[31:16] = 16'h0040; s_rdata = 32'hDEAD_BEEF;
    step;
    check("to_grant", grant, 1);
    check("to_ready", m_ready, 2'b10);
    step;
    m_avalid = 2'b00;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      #1;
      if (m_rvalid !== 2'b00 || err !== 1'b0) bad++;
      step;
    end
    check("to_quiet", bad, 0);
    check("to_rvalid", m_rvalid, 2'b10);
    check("to_rdata", m_rdata, 0);
    step;
    check("to_err", err, 1);
    s_rvalid = 1'b1;
    #1;
    check("to_late_rvalid", m_rvalid, 0);
    step;
    s_rvalid = 1'b0;
    m_avalid = 2'b01; m_addr[15:0] = 16'h0050; m_wstrb = 8'h0F;
    step;
    check("to_next_grant", grant, 0);
    check("to_next_ready", m_ready, 2'b01);
    step;
    m_avalid = 2'b00;
    #1;
    check("to_err_sticky", err, 1);
    // reset while manager 1 waits for read data
    m_avalid = 2'b10; m_wstrb = 8'h00;
    step;
    check("rr_rd_grant", grant, 1);
    step;
    m_avalid = 2'b00;
    step;
    arst = 1'b1; s_rvalid = 1'b1;
    #1;
    check("mr_grant", grant, 0);
    check("mr_err", err, 0);
    check("mr_rvalid", m_rvalid, 0);
    check("mr_ready", m_ready, 0);
    check("mr_savalid", s_avalid, 0);
    #2 arst = 1'b0;
    step;
    check("mr_post_rvalid", m_rvalid, 0);
    check("mr_post_err", err, 0);
    s_rvalid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
